// File: rtl/shift_pkg.sv
// Shared types and line-level constants for the byte serializer.
package shift_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned BIT_CNT_W = 3;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/serial_tx8_bit_timer.sv
// Bit-period timer: tick marks the last cycle of each CLKS_PER_BIT-cycle bit.
module bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  if (CLKS_PER_BIT < 1) begin : g_bad_cpb
    $error("bit_timer: CLKS_PER_BIT must be >= 1");
  end

  // Free-running wrap counter, restarted so a new frame gets a full first bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || (cnt == CNT_LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/serial_tx8.sv
// Framed LSB-first serializer: start, 8 data, optional even parity, stop.
// Parity bit enabled by defining SERIAL_TX8_PARITY_EN.
module serial_tx8
  import shift_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned DATA_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] d_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  if (DATA_W != DATA_BITS) begin : g_bad_width
    $error("serial_tx8: DATA_W must be 8");
  end

  tx_state_t                 state, state_next;
  logic [DATA_BITS-1:0]      shift_q, shift_next;
  logic [BIT_CNT_W-1:0]      bit_cnt, bit_next;
  logic                      tx_next;
  logic                      done_next;
  logic                      accept;
  logic                      tick;
`ifdef SERIAL_TX8_PARITY_EN
  logic                      parity_q, parity_next;
`endif

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .reset(reset),
    .clear(accept),
    .tick (tick)
  );

  // State and datapath registers; reset drops the line to idle immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shift_q <= '0;
      bit_cnt <= '0;
      tx_out  <= LINE_IDLE;
      done    <= 1'b0;
`ifdef SERIAL_TX8_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      shift_q <= shift_next;
      bit_cnt <= bit_next;
      tx_out  <= tx_next;
      done    <= done_next;
`ifdef SERIAL_TX8_PARITY_EN
      parity_q <= parity_next;
`endif
    end
  end

  // Next-state and next-line decode; tx_out only moves on bit boundaries.
  always_comb begin
    state_next = state;
    shift_next = shift_q;
    bit_next   = bit_cnt;
    tx_next    = tx_out;
    done_next  = 1'b0;
`ifdef SERIAL_TX8_PARITY_EN
    parity_next = parity_q;
`endif

    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next = START;
          shift_next = DATA_BITS'(d_in);
          bit_next   = '0;
          tx_next    = START_BIT;
`ifdef SERIAL_TX8_PARITY_EN
          parity_next = even_parity(DATA_BITS'(d_in));
`endif
        end
      end

      START: begin
        if (tick) begin
          state_next = DATA;
          tx_next    = shift_q[0];
        end
      end

      DATA: begin
        if (tick) begin
          if (bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) begin
`ifdef SERIAL_TX8_PARITY_EN
            state_next = PARITY;
            tx_next    = parity_q;
`else
            state_next = STOP;
            tx_next    = STOP_BIT;
`endif
          end else begin
            shift_next = {1'b0, shift_q[DATA_BITS-1:1]};
            tx_next    = shift_q[1];
            bit_next   = bit_cnt + BIT_CNT_W'(1);
          end
        end
      end

`ifdef SERIAL_TX8_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_next = STOP;
          tx_next    = STOP_BIT;
        end
      end
`endif

      STOP: begin
        if (tick) begin
          state_next = IDLE;
          tx_next    = LINE_IDLE;
          done_next  = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        tx_next    = LINE_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_tx8.sv
// Directed bench for serial_tx8 at CLKS_PER_BIT = 4, 1 and 2.
module tb_serial_tx8;

`ifdef SERIAL_TX8_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] d_in = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready_o [3];
  logic       tx_o [3];
  logic       busy_o [3];
  logic       done_o [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_tx8 #(.CLKS_PER_BIT(4)) u_dut4 (
    .clk(clk), .reset(reset), .d_in(d_in), .in_valid(in_valid),
    .in_ready(in_ready_o[0]), .tx_out(tx_o[0]), .busy(busy_o[0]), .done(done_o[0])
  );
  serial_tx8 #(.CLKS_PER_BIT(1)) u_dut1 (
    .clk(clk), .reset(reset), .d_in(d_in), .in_valid(in_valid),
    .in_ready(in_ready_o[1]), .tx_out(tx_o[1]), .busy(busy_o[1]), .done(done_o[1])
  );
  serial_tx8 #(.CLKS_PER_BIT(2)) u_dut2 (
    .clk(clk), .reset(reset), .d_in(d_in), .in_valid(in_valid),
    .in_ready(in_ready_o[2]), .tx_out(tx_o[2]), .busy(busy_o[2]), .done(done_o[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (NB == 11 && idx == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic tick_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    tick_sample();
    tick_sample();
    reset = 1'b0;
  endtask

  // Called at #1 after the accept edge; ends #1 after the edge starting the done cycle.
  task automatic expect_frame(input int sel, input int cpb, input logic [7:0] b,
                              input string tag, input int pulse_at);
    for (int c = 1; c <= NB * cpb; c++) begin
      check({tag, " tx"}, 32'(tx_o[sel]), 32'(frame_bit(b, (c - 1) / cpb)));
      if (c % cpb == 1 || cpb == 1) begin
        check({tag, " busy"}, 32'(busy_o[sel]), 32'd1);
        check({tag, " in_ready"}, 32'(in_ready_o[sel]), 32'd0);
        check({tag, " done early"}, 32'(done_o[sel]), 32'd0);
      end
      if (pulse_at > 0 && c == pulse_at) begin
        in_valid = 1'b1;
        d_in = 8'hFF;
      end else if (pulse_at > 0 && c == pulse_at + 1) begin
        in_valid = 1'b0;
      end
      tick_sample();
    end
    check({tag, " done"}, 32'(done_o[sel]), 32'd1);
    check({tag, " ready@done"}, 32'(in_ready_o[sel]), 32'd1);
    check({tag, " idle line"}, 32'(tx_o[sel]), 32'd1);
  endtask

  task automatic send(input int sel, input int cpb, input logic [7:0] b, input string tag);
    check({tag, " ready"}, 32'(in_ready_o[sel]), 32'd1);
    d_in = b;
    in_valid = 1'b1;
    tick_sample();
    in_valid = 1'b0;
    expect_frame(sel, cpb, b, tag, 0);
    tick_sample();
    check({tag, " done gone"}, 32'(done_o[sel]), 32'd0);
    check({tag, " busy gone"}, 32'(busy_o[sel]), 32'd0);
  endtask

  initial begin
    int dones;

    do_reset();
    check("rst tx", 32'(tx_o[0]), 32'd1);
    check("rst ready", 32'(in_ready_o[0]), 32'd1);
    check("rst busy", 32'(busy_o[0]), 32'd0);
    check("rst done", 32'(done_o[0]), 32'd0);

    send(0, 4, 8'hA5, "basic_a5");

    // Back-to-back: in_valid held so the second byte goes in the done cycle.
    do_reset();
    d_in = 8'h3C;
    in_valid = 1'b1;
    tick_sample();
    d_in = 8'h81;
    expect_frame(0, 4, 8'h3C, "b2b_3c", 0);
    tick_sample();
    in_valid = 1'b0;
    expect_frame(0, 4, 8'h81, "b2b_81", 0);
    tick_sample();
    check("b2b done gone", 32'(done_o[0]), 32'd0);

    // Ignore while busy: FF pulse mid-frame of 00 must not appear.
    do_reset();
    d_in = 8'h00;
    in_valid = 1'b1;
    tick_sample();
    in_valid = 1'b0;
    expect_frame(0, 4, 8'h00, "ignore_00", 15);
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      tick_sample();
      if (done_o[0]) dones++;
      if (i == 30) check("ignore line idle", 32'(tx_o[0]), 32'd1);
    end
    check("ignore extra done", 32'(dones), 32'd0);
    check("ignore not busy", 32'(busy_o[0]), 32'd0);

    // Reset during data bit 3 of 55 (cycles 17..20 after accept).
    do_reset();
    d_in = 8'h55;
    in_valid = 1'b1;
    tick_sample();
    in_valid = 1'b0;
    for (int c = 1; c < 18; c++) tick_sample();
    check("midrst bit3", 32'(tx_o[0]), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("midrst tx", 32'(tx_o[0]), 32'd1);
    check("midrst busy", 32'(busy_o[0]), 32'd0);
    check("midrst ready", 32'(in_ready_o[0]), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 50; i++) begin
      tick_sample();
      if (done_o[0]) dones++;
    end
    check("midrst no done", 32'(dones), 32'd0);
    send(0, 4, 8'h0F, "after_rst_0f");

    do_reset();
    send(1, 1, 8'hC3, "fast_c3");

    do_reset();
`ifdef SERIAL_TX8_PARITY_EN
    send(2, 2, 8'hA5, "par_a5");
    send(2, 2, 8'hA4, "par_a4");
`else
    send(2, 2, 8'hA4, "cpb2_a4");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
